// File: rtl/mem_arb.sv
// Two-port round-robin arbiter sharing one request/ack data memory port.
// Optional abort-on-timeout in WAIT is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arb #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic [1:0]    width0,
    output logic          done0,
    output logic          err0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic [1:0]    width1,
    output logic          done1,
    output logic          err1,
    output logic [DW-1:0] rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [1:0]    mem_width,
    output logic          mem_owner,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_last_grant;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [1:0]    r_width;
    logic          r_owner;
    logic          r_err;
    logic [DW-1:0] r_rdata;
    logic          w_any_req;
    logic          w_winner;
    logic          w_finish;
    logic          w_timeout;

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("mem_arb: TIMEOUT must be >= 1");
    end

    assign w_any_req = req0 | req1;
    // On a tie the port that did not win last time gets the grant.
    assign w_winner  = (req0 && req1) ? ~r_last_grant : req1;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [31:0] r_cnt;

    assign w_timeout = (r_state == S_WAIT) && !mem_ack && (r_cnt == TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            if (!mem_ack) r_cnt <= r_cnt + 32'd1;
        end else begin
            r_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_finish = (r_state == S_WAIT) && (mem_ack || w_timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next = S_WAIT;
            S_WAIT:  if (w_finish)  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_width      <= '0;
            r_owner      <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_owner <= w_winner;
            r_err   <= 1'b0;
            r_we    <= w_winner ? we1    : we0;
            r_addr  <= w_winner ? addr1  : addr0;
            r_wdata <= w_winner ? wdata1 : wdata0;
            r_width <= w_winner ? width1 : width0;
        end else if (w_finish) begin
            // An ack coinciding with the timeout completes normally.
            r_last_grant <= r_owner;
            r_err        <= w_timeout;
            r_rdata      <= (mem_ack && !r_we) ? mem_rdata : '0;
        end
    end

    always_comb begin
        mem_req   = (r_state == S_WAIT);
        mem_we    = r_we;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        mem_width = r_width;
        mem_owner = r_owner;
        rdata     = r_rdata;
        done0     = (r_state == S_DONE) && !r_owner;
        done1     = (r_state == S_DONE) &&  r_owner;
        err0      = done0 && r_err;
        err1      = done1 && r_err;
    end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: cycle vector table plus hand sequences for
// fairness, wait states, reset in WAIT and (with MEM_ARB_TIMEOUT_EN) timeout.
module tb_mem_arb;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [1:0]    width0, width1;
    logic          done0, err0, done1, err1;
    logic [DW-1:0] rdata;
    logic          mem_req, mem_we, mem_owner, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    mem_width;

    int n_chk  = 0;
    int n_fail = 0;

    mem_arb #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .width0(width0),
        .done0(done0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .width1(width1),
        .done1(done1), .err1(err1),
        .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_width(mem_width), .mem_owner(mem_owner),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        r0;
        logic        r1;
        logic        ack;
        logic [31:0] mrd;
        logic        e_req;
        logic        e_own;
        logic        e_d0;
        logic        e_d1;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(input logic rst, input logic r0, input logic r1, input logic ack,
                                input logic [31:0] mrd, input logic e_req, input logic e_own,
                                input logic e_d0, input logic e_d1, input logic [31:0] e_rd);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.ack = ack; v.mrd = mrd;
        v.e_req = e_req; v.e_own = e_own; v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          n_done;
        logic        exp_own;

        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hA5A5_A5A5; width0 = 2'b10;
        we1 = 1'b0; addr1 = 32'h20; wdata1 = 32'h0BAD_0BAD; width1 = 2'b10;

        // Single port, zero wait, then tie after reset, then alternation from last_grant.
        tbl[0] = mk(0, 1, 0, 0, 32'h0,         1, 0, 0, 0, 32'h0);
        tbl[1] = mk(0, 1, 0, 1, 32'hDEAD_BEEF, 0, 0, 1, 0, 32'h0);
        tbl[2] = mk(0, 0, 0, 1, 32'h0,         0, 0, 0, 0, 32'h0);
        tbl[3] = mk(1, 1, 1, 0, 32'h0,         0, 0, 0, 0, 32'h0);
        tbl[4] = mk(0, 1, 1, 0, 32'h0,         1, 0, 0, 0, 32'h0);
        tbl[5] = mk(0, 1, 1, 1, 32'h0,         0, 0, 1, 0, 32'h0);
        tbl[6] = mk(0, 0, 1, 1, 32'h0,         0, 0, 0, 0, 32'h0);
        tbl[7] = mk(0, 1, 1, 0, 32'h0,         1, 1, 0, 0, 32'h0);
        tbl[8] = mk(0, 1, 1, 1, 32'h1234_5678, 0, 1, 0, 1, 32'h1234_5678);
        tbl[9] = mk(0, 1, 0, 0, 32'h0,         0, 1, 0, 0, 32'h0);

        tick();
        tick();
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset done", 32'({done0, done1, err0, err1}), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset rdata", rdata, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            rst_n = ~tbl[i].rst; req0 = tbl[i].r0; req1 = tbl[i].r1;
            mem_ack = tbl[i].ack; mem_rdata = tbl[i].mrd;
            tick();
            chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(tbl[i].e_req));
            chk($sformatf("v%0d mem_owner", i), 32'(mem_owner), 32'(tbl[i].e_own));
            chk($sformatf("v%0d done0", i), 32'(done0), 32'(tbl[i].e_d0));
            chk($sformatf("v%0d done1", i), 32'(done1), 32'(tbl[i].e_d1));
            if (tbl[i].e_d0 || tbl[i].e_d1) begin
                chk($sformatf("v%0d rdata", i), rdata, tbl[i].e_rd);
                chk($sformatf("v%0d err", i), 32'({err0, err1}), 32'd0);
            end
            if (i == 0) begin
                chk("v0 mem_addr", mem_addr, 32'h10);
                chk("v0 mem_wdata", mem_wdata, 32'hA5A5_A5A5);
                chk("v0 mem_width", 32'(mem_width), 32'd2);
                chk("v0 mem_we", 32'(mem_we), 32'd1);
            end
        end
        rst_n = 1'b1;

        // Continuous dual requests with ack held high: strict 0,1,0,1 alternation.
        req0 = 1'b1; req1 = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        n_done = 0; exp_own = 1'b0;
        for (int c = 0; c < 18; c++) begin
            tick();
            chk("t3 done overlap", 32'(done0 & done1), 32'd0);
            if (done0 || done1) begin
                chk("t3 grant", 32'(done1), 32'(exp_own));
                chk("t3 rdata", rdata, exp_own ? 32'hCAFE_F00D : 32'h0);
                exp_own = ~exp_own;
                n_done++;
            end
        end
        chk("t3 done count", 32'(n_done), 32'd6);

        // Port 1 load with three wait states; requester inputs change after latch.
        req0 = 1'b0; req1 = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        tick();
        chk("t4 mem_req", 32'(mem_req), 32'd1);
        chk("t4 mem_owner", 32'(mem_owner), 32'd1);
        chk("t4 mem_addr", mem_addr, 32'h20);
        addr1 = 32'hFFFF_FFF0; we1 = 1'b1; req1 = 1'b0;
        for (int w = 0; w < 3; w++) begin
            tick();
            chk("t4 hold mem_req", 32'(mem_req), 32'd1);
            chk("t4 hold mem_addr", mem_addr, 32'h20);
            chk("t4 hold mem_we", 32'(mem_we), 32'd0);
            chk("t4 hold done1", 32'(done1), 32'd0);
        end
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        chk("t4 done1", 32'(done1), 32'd1);
        chk("t4 rdata", rdata, 32'h1234_5678);
        chk("t4 err1", 32'(err1), 32'd0);
        chk("t4 mem_req drop", 32'(mem_req), 32'd0);
        mem_ack = 1'b0; addr1 = 32'h20; we1 = 1'b0;
        tick();

        // Port 0 wins once so last_grant=0, then reset while in WAIT.
        req0 = 1'b1;
        tick();
        mem_ack = 1'b1;
        tick();
        chk("t5 pre done0", 32'(done0), 32'd1);
        req0 = 1'b0; mem_ack = 1'b0;
        tick();
        req0 = 1'b1;
        tick();
        chk("t5 in WAIT", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 async mem_req", 32'(mem_req), 32'd0);
        req1 = 1'b1;
        tick();
        chk("t5 no done", 32'({done0, done1}), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t5 post-reset owner", 32'(mem_owner), 32'd0);
        chk("t5 post-reset mem_req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        tick();
        chk("t5 post-reset done0", 32'(done0), 32'd1);
        req0 = 1'b0; req1 = 1'b0; mem_ack = 1'b0;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // Load leaves nonzero rdata, then an unanswered load times out after 4 WAIT cycles.
        we0 = 1'b0; req0 = 1'b1; mem_rdata = 32'h55AA;
        tick();
        mem_ack = 1'b1;
        tick();
        chk("t6 load rdata", rdata, 32'h55AA);
        req0 = 1'b0; mem_ack = 1'b0;
        tick();
        req0 = 1'b1;
        tick();
        for (int w = 0; w < 3; w++) begin
            tick();
            chk("t6 waiting", 32'({mem_req, done0}), 32'b10);
        end
        tick();
        chk("t6 timeout done0", 32'(done0), 32'd1);
        chk("t6 timeout err0", 32'(err0), 32'd1);
        chk("t6 timeout rdata", rdata, 32'd0);
        chk("t6 timeout mem_req", 32'(mem_req), 32'd0);
        req0 = 1'b0;
        tick();
        req0 = 1'b1;
        tick();
        repeat (3) tick();
        mem_ack = 1'b1; mem_rdata = 32'h7777_0001;
        tick();
        chk("t6 tie done0", 32'(done0), 32'd1);
        chk("t6 tie err0", 32'(err0), 32'd0);
        chk("t6 tie rdata", rdata, 32'h7777_0001);
        req0 = 1'b0; mem_ack = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
